// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding and default sizing for the SPI flash path
package spi_pkg;
  localparam int SPI_DATA_W  = 8;
  localparam int SPI_CLK_DIV = 2;
  localparam int SPI_CS_IDLE = 2;
  typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, NEXT, CS_HOLD, CS_GAP} state_t;
endpackage

// File: rtl/spi_clk_gen.sv
// spi_clk_gen: half-period counter producing s_clk and edge strobes while shifting
module spi_clk_gen
  import spi_pkg::*;
#(
  parameter int CLK_DIV = SPI_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic s_clk_o,
  output logic rise_o,
  output logic fall_o,
  output logic end_o
);
  localparam int HW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [HW-1:0] HMAX = HW'(CLK_DIV - 1);
  logic [HW-1:0] half_q, half_d;
  logic phase_q, phase_d;
  logic wrap;
  // phase_q=0 is the high half of a bit, 1 the low half; both wrap to 0 when disabled
  always_comb begin
    wrap = half_q == HMAX;
    half_d = (en_i && !wrap) ? half_q + 1'b1 : '0;
    phase_d = en_i && (wrap ? !phase_q : phase_q);
    s_clk_o = en_i && !phase_q;
    rise_o = s_clk_o && half_q == '0;
    fall_o = s_clk_o && wrap;
    end_o = en_i && phase_q && wrap;
  end
  // counter registers
  always_ff @(posedge clk)
    if (rst) begin
      half_q <= '0;
      phase_q <= 1'b0;
    end else begin
      half_q <= half_d;
      phase_q <= phase_d;
    end
endmodule

// File: rtl/spi_byte_engine.sv
// spi_byte_engine: SPI mode-0 byte engine for NOR flash; define SPI_LSB_FIRST_EN for LSB-first bit order
module spi_byte_engine
  import spi_pkg::*;
#(
  parameter int DATA_W  = SPI_DATA_W,
  parameter int CLK_DIV = SPI_CLK_DIV,
  parameter int CS_IDLE = SPI_CS_IDLE
) (
  input  logic              p_clk,
  input  logic              p_reset,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_last,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              s_clk,
  output logic              s_mosi,
  input  logic              s_miso,
  output logic              s_css
);
`ifdef SPI_LSB_FIRST_EN
  localparam bit LSB_FIRST = 1'b1;
`else
  localparam bit LSB_FIRST = 1'b0;
`endif
  localparam int BW = $clog2(DATA_W + 1);
  localparam int OUT_BIT = LSB_FIRST ? 0 : DATA_W - 1;
  state_t state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [DATA_W-1:0] tx_q, tx_d, rx_q, rx_d, rx_data_q, rx_data_d;
  logic last_q, last_d;
  logic accept, done, clk_en, rise, fall, bit_end;

  // done is the single cycle after the last low half-period, where the byte is reported
  assign done = state_q == SHIFT && bit_q == BW'(DATA_W);
  assign clk_en = state_q == SHIFT && !done;
  assign rx_data = rx_data_q;

  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk    (p_clk),
    .rst    (p_reset),
    .en_i   (clk_en),
    .s_clk_o(s_clk),
    .rise_o (rise),
    .fall_o (fall),
    .end_o  (bit_end)
  );

  // next-state, pin outputs and datapath updates
  always_comb begin
    tx_ready = !p_reset && (state_q == IDLE || state_q == NEXT);
    busy = state_q != IDLE;
    s_css = state_q == IDLE || state_q == CS_GAP;
    s_mosi = !s_css && tx_q[OUT_BIT];
    rx_valid = done;
    accept = tx_valid && tx_ready;
    state_d = state_q;
    case (state_q)
      IDLE:     if (accept) state_d = CS_SETUP;
      CS_SETUP: if (cnt_q == 16'(CLK_DIV - 1)) state_d = SHIFT;
      SHIFT:    if (done) state_d = last_q ? CS_HOLD : NEXT;
      NEXT:     if (accept) state_d = SHIFT;
      CS_HOLD:  if (cnt_q == 16'(CLK_DIV - 1)) state_d = CS_GAP;
      CS_GAP:   if (cnt_q == 16'(CS_IDLE - 1)) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    cnt_d = state_d != state_q ? '0 : cnt_q + 16'd1;
    bit_d = state_d != state_q ? '0 : bit_end ? bit_q + 1'b1 : bit_q;
    tx_d = accept ? tx_data
         : (fall && bit_q != BW'(DATA_W - 1)) ? (LSB_FIRST ? tx_q >> 1 : tx_q << 1)
         : tx_q;
    rx_d = rise ? (LSB_FIRST ? {s_miso, rx_q[DATA_W-1:1]} : {rx_q[DATA_W-2:0], s_miso}) : rx_q;
    rx_data_d = (bit_end && bit_q == BW'(DATA_W - 1)) ? rx_q : rx_data_q;
    last_d = accept ? tx_last : last_q;
  end

  // state and datapath registers; a partial byte never reaches rx_data
  always_ff @(posedge p_clk)
    if (p_reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      tx_q <= '0;
      rx_q <= '0;
      rx_data_q <= '0;
      last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      tx_q <= tx_d;
      rx_q <= rx_d;
      rx_data_q <= rx_data_d;
      last_q <= last_d;
    end
endmodule

// File: tb/tb_spi_byte_engine.sv
// tb_spi_byte_engine: directed bench for spi_byte_engine with loopback and flash-response model
module tb_spi_byte_engine;
  logic p_clk = 1'b0, p_reset = 1'b1, tx_valid = 1'b0, tx_last = 1'b0, loop = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic tx_ready, rx_valid, busy, s_clk, s_mosi, s_miso, s_css;
  logic [7:0] rx_data;
  logic [7:0] miso_sh = 8'h00;
  logic css_m = 1'b1, prev_sclk = 1'b0, prev_css = 1'b1;
  int checks = 0, fails = 0, cyc = 0, edges = 0, acc_cnt = 0, next_bad = 0, run = 0, bcnt = 0;
  int rx_cyc = -1, fall_cyc = -1, rise_cyc = -1;
  logic mosi_q[$];
  logic [7:0] rxq[$];
  logic [7:0] resp[$];
  int runs[$];
`ifdef SPI_LSB_FIRST_EN
  localparam bit LSB = 1'b1;
`else
  localparam bit LSB = 1'b0;
`endif

  spi_byte_engine dut (
    .p_clk(p_clk), .p_reset(p_reset), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_data(tx_data), .tx_last(tx_last), .rx_valid(rx_valid), .rx_data(rx_data),
    .busy(busy), .s_clk(s_clk), .s_mosi(s_mosi), .s_miso(s_miso), .s_css(s_css)
  );

  always #5 p_clk = ~p_clk;
  always @(posedge p_clk) cyc++;

  assign s_miso = loop ? s_mosi : (LSB ? miso_sh[0] : miso_sh[7]);

  // flash model: loads a response byte when CS falls and after every 8th falling s_clk
  always @(s_css or negedge s_clk) begin
    if (s_css !== 1'b0) css_m = 1'b1;
    else if (css_m) begin
      css_m = 1'b0;
      bcnt = 0;
      if (resp.size() > 0) miso_sh = resp.pop_front(); else miso_sh = 8'h00;
    end else begin
      bcnt++;
      if (bcnt == 8) begin
        bcnt = 0;
        if (resp.size() > 0) miso_sh = resp.pop_front(); else miso_sh = 8'h00;
      end else miso_sh = LSB ? miso_sh >> 1 : miso_sh << 1;
    end
  end

  // pin monitor sampled mid-cycle
  always @(negedge p_clk) begin
    if (rx_valid === 1'b1) begin rxq.push_back(rx_data); rx_cyc = cyc; end
    if (s_clk === 1'b1 && prev_sclk === 1'b0) begin
      mosi_q.push_back(s_mosi);
      edges++;
      if (rise_cyc < 0) rise_cyc = cyc;
    end
    if (s_css === 1'b0 && prev_css === 1'b1) fall_cyc = cyc;
    if (s_css === 1'b0) run++;
    else if (run != 0) begin runs.push_back(run); run = 0; end
    if (s_css === 1'b0 && tx_ready === 1'b1 && s_clk !== 1'b0) next_bad++;
    if (tx_valid === 1'b1 && tx_ready === 1'b1) acc_cnt++;
    prev_sclk = s_clk;
    prev_css = s_css;
  end

  function automatic logic [7:0] pack8(input int base);
    logic [7:0] v = 8'h00;
    for (int i = 0; i < 8; i++) v = {v[6:0], mosi_q[base+i]};
    return v;
  endfunction

  task automatic tick();
    @(posedge p_clk);
    #1;
  endtask

  task automatic clr();
    mosi_q.delete(); rxq.delete(); runs.delete();
    edges = 0; next_bad = 0; rise_cyc = -1; fall_cyc = -1; rx_cyc = -1;
  endtask

  task automatic send(input logic [7:0] d, input logic l, output int t);
    int n = 0;
    tx_valid = 1'b1; tx_data = d; tx_last = l;
    while (tx_ready !== 1'b1 && n < 200) begin tick(); n++; end
    checks++;
    if (tx_ready !== 1'b1) begin fails++; $display("FAIL send_timeout: tx_ready=%b required 1 for byte %h", tx_ready, d); end
    t = cyc;
    tick();
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 300) begin tick(); n++; end
    checks++;
    if (busy !== 1'b0) begin fails++; $display("FAIL idle_timeout: busy=%b required 0", busy); end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks += 7;
    if (tx_ready !== 1'b0) begin fails++; $display("FAIL rst_tx_ready: got %b want 0", tx_ready); end
    if (rx_valid !== 1'b0) begin fails++; $display("FAIL rst_rx_valid: got %b want 0", rx_valid); end
    if (rx_data !== 8'h00) begin fails++; $display("FAIL rst_rx_data: got %h want 00", rx_data); end
    if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b want 0", busy); end
    if (s_clk !== 1'b0) begin fails++; $display("FAIL rst_s_clk: got %b want 0", s_clk); end
    if (s_mosi !== 1'b0) begin fails++; $display("FAIL rst_s_mosi: got %b want 0", s_mosi); end
    if (s_css !== 1'b1) begin fails++; $display("FAIL rst_s_css: got %b want 1", s_css); end
    p_reset = 1'b0;
    tick();
    checks++;
    if (tx_ready !== 1'b1) begin fails++; $display("FAIL rst_release_ready: got %b want 1", tx_ready); end
  endtask

  task automatic test_single();
    int t, n = 0;
    clr(); loop = 1'b1;
    send(8'hA5, 1'b1, t);
    while (s_css !== 1'b1 && n < 100) begin tick(); n++; end
    n = 0;
    while (tx_ready !== 1'b1 && n < 10) begin n++; tick(); end
    checks += 8;
    if (n != 2) begin fails++; $display("FAIL single_cs_gap: got %0d cycles want 2", n); end
    if (edges != 8) begin fails++; $display("FAIL single_edges: got %0d want 8", edges); end
    if (edges == 8 && pack8(0) !== 8'hA5) begin fails++; $display("FAIL single_mosi: got %h want a5", pack8(0)); end
    if (rxq.size() != 1 || rxq[0] !== 8'hA5) begin fails++; $display("FAIL single_rx: got n=%0d first=%h want 1 x a5", rxq.size(), rxq.size() ? rxq[0] : 8'h00); end
    if (runs.size() != 1 || runs[0] != 37) begin fails++; $display("FAIL single_css_low: got n=%0d len=%0d want 1 x 37", runs.size(), runs.size() ? runs[0] : 0); end
    if (fall_cyc != t + 1) begin fails++; $display("FAIL single_css_fall: got %0d want %0d", fall_cyc, t + 1); end
    if (rise_cyc != t + 3) begin fails++; $display("FAIL single_first_rise: got %0d want %0d", rise_cyc, t + 3); end
    if (rx_cyc != t + 35) begin fails++; $display("FAIL single_rx_latency: got %0d want %0d", rx_cyc, t + 35); end
  endtask

  task automatic test_frame();
    int t;
    clr(); loop = 1'b0;
    resp = '{8'h00, 8'hEF, 8'h40, 8'h18};
    send(8'h9F, 1'b0, t);
    send(8'h00, 1'b0, t);
    send(8'h00, 1'b0, t);
    send(8'h00, 1'b1, t);
    wait_idle();
    checks += 6;
    if (runs.size() != 1) begin fails++; $display("FAIL frame_css_continuous: got %0d low runs want 1", runs.size()); end
    if (rxq.size() != 4) begin fails++; $display("FAIL frame_rx_count: got %0d want 4", rxq.size()); end
    if (rxq.size() == 4 && rxq[1] !== 8'hEF) begin fails++; $display("FAIL frame_rx1: got %h want ef", rxq[1]); end
    if (rxq.size() == 4 && rxq[2] !== 8'h40) begin fails++; $display("FAIL frame_rx2: got %h want 40", rxq[2]); end
    if (rxq.size() == 4 && rxq[3] !== 8'h18) begin fails++; $display("FAIL frame_rx3: got %h want 18", rxq[3]); end
    if (next_bad != 0 || edges != 32) begin fails++; $display("FAIL frame_sclk: next_high=%0d edges=%0d want 0 and 32", next_bad, edges); end
    loop = 1'b1;
  endtask

  task automatic test_gap();
    int t, n = 0, e, bad = 0;
    clr(); loop = 1'b1;
    send(8'h3C, 1'b0, t);
    while (tx_ready !== 1'b1 && n < 100) begin tick(); n++; end
    e = edges;
    repeat (5) begin
      tick();
      if (s_clk !== 1'b0 || s_css !== 1'b0 || tx_ready !== 1'b1) bad++;
    end
    checks += 2;
    if (bad != 0) begin fails++; $display("FAIL gap_static: got %0d bad cycles want 0", bad); end
    if (edges != e) begin fails++; $display("FAIL gap_edges: got %0d want %0d", edges, e); end
    send(8'h81, 1'b1, t);
    checks += 2;
    if (s_clk !== 1'b1) begin fails++; $display("FAIL gap_resume_sclk: got %b want 1", s_clk); end
    if (s_mosi !== 1'b1) begin fails++; $display("FAIL gap_resume_msb: got %b want 1", s_mosi); end
    wait_idle();
    checks += 4;
    if (runs.size() != 1 || runs[0] != 76) begin fails++; $display("FAIL gap_css_low: got n=%0d len=%0d want 1 x 76", runs.size(), runs.size() ? runs[0] : 0); end
    if (edges != 16) begin fails++; $display("FAIL gap_total_edges: got %0d want 16", edges); end
    if (edges == 16 && pack8(8) !== 8'h81) begin fails++; $display("FAIL gap_mosi2: got %h want 81", pack8(8)); end
    if (rxq.size() != 2 || rxq[0] !== 8'h3C || rxq[1] !== 8'h81) begin fails++; $display("FAIL gap_rx: got n=%0d want 3c,81", rxq.size()); end
  endtask

  task automatic test_reset_mid();
    int t, n = 0;
    clr(); loop = 1'b1;
    send(8'hFF, 1'b1, t);
    while (edges < 4 && n < 100) begin tick(); n++; end
    p_reset = 1'b1;
    tick();
    checks += 4;
    if (s_css !== 1'b1) begin fails++; $display("FAIL rmid_css: got %b want 1", s_css); end
    if (s_clk !== 1'b0) begin fails++; $display("FAIL rmid_sclk: got %b want 0", s_clk); end
    if (tx_ready !== 1'b0) begin fails++; $display("FAIL rmid_ready_in_reset: got %b want 0", tx_ready); end
    if (busy !== 1'b0) begin fails++; $display("FAIL rmid_busy: got %b want 0", busy); end
    p_reset = 1'b0;
    tick();
    checks++;
    if (tx_ready !== 1'b1) begin fails++; $display("FAIL rmid_ready_after: got %b want 1", tx_ready); end
    repeat (40) tick();
    checks += 3;
    if (rxq.size() != 0) begin fails++; $display("FAIL rmid_rx_valid: got %0d pulses want 0", rxq.size()); end
    if (rx_data !== 8'h00) begin fails++; $display("FAIL rmid_rx_data: got %h want 00", rx_data); end
    if (edges != 4) begin fails++; $display("FAIL rmid_edges: got %0d want 4", edges); end
  endtask

  task automatic test_hold_valid();
    int t, n = 0, k, a0;
    clr(); loop = 1'b1;
    a0 = acc_cnt;
    send(8'h5A, 1'b1, t);
    tx_valid = 1'b1; tx_data = 8'h66; tx_last = 1'b1;
    while (tx_ready !== 1'b1 && n < 100) begin tick(); n++; end
    k = cyc;
    tick();
    tx_valid = 1'b0;
    wait_idle();
    checks += 3;
    if (k != t + 40) begin fails++; $display("FAIL hold_accept_cycle: got %0d want %0d", k, t + 40); end
    if (acc_cnt - a0 != 2) begin fails++; $display("FAIL hold_accept_count: got %0d want 2", acc_cnt - a0); end
    if (rxq.size() != 2 || rxq[0] !== 8'h5A || rxq[1] !== 8'h66) begin fails++; $display("FAIL hold_rx: got n=%0d want 5a,66", rxq.size()); end
  endtask

  task automatic test_bit_order();
    int t;
    clr(); loop = 1'b1;
    send(8'h01, 1'b1, t);
    wait_idle();
    checks += 3;
    if (edges != 8) begin fails++; $display("FAIL order_edges: got %0d want 8", edges); end
    if (edges == 8 && pack8(0) !== (LSB ? 8'h80 : 8'h01)) begin fails++; $display("FAIL order_mosi: got %h want %h", pack8(0), LSB ? 8'h80 : 8'h01); end
    if (rxq.size() != 1 || rxq[0] !== 8'h01) begin fails++; $display("FAIL order_rx: got n=%0d want 1 x 01", rxq.size()); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_frame();
    test_gap();
    test_reset_mid();
    test_hold_valid();
    test_bit_order();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
